// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, scan-code constants and event layout for the PS/2 key sequencer
package ps2_pkg;

  localparam int CODE_W = 8;
  localparam int MODS_W = 4;
  localparam int EVT_W  = MODS_W + 2 + CODE_W;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } ps2_state_t;

  typedef struct packed {
    logic [MODS_W-1:0] mods;
    logic              rel;
    logic              ext;
    logic [CODE_W-1:0] code;
  } ps2_evt_t;

  typedef struct packed {
    logic caps;
    logic caps_held;
    logic ralt;
    logic lalt;
    logic rctrl;
    logic lctrl;
    logic rshift;
    logic lshift;
  } ps2_keys_t;

  // Keyboard housekeeping replies that never produce a key event.
  function automatic logic is_ignored(input logic [7:0] code);
    return code inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  function automatic ps2_keys_t key_update(input ps2_keys_t k, input logic [7:0] code,
                                           input logic ext, input logic rel);
    ps2_keys_t n;
    n = k;
    case (code)
      SC_LSHIFT: n.lshift = !rel;
      SC_RSHIFT: n.rshift = !rel;
      SC_CTRL: if (ext) n.rctrl = !rel; else n.lctrl = !rel;
      SC_ALT:  if (ext) n.ralt  = !rel; else n.lalt  = !rel;
      SC_CAPS: begin
        // Typematic repeats arrive with the held bit already set and must not toggle.
        if (!rel && !k.caps_held) n.caps = !k.caps;
        n.caps_held = !rel;
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [MODS_W-1:0] mods_of(input ps2_keys_t k);
    return {k.caps, k.lalt | k.ralt, k.lctrl | k.rctrl, k.lshift | k.rshift};
  endfunction

  function automatic ps2_evt_t build_evt(input ps2_keys_t k, input logic [7:0] code,
                                         input logic ext, input logic rel);
    ps2_evt_t e;
    e.mods = mods_of(key_update(k, code, ext, rel));
    e.rel  = rel;
    e.ext  = ext;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - key event FIFO with sticky overflow, full-with-pop accepts a push
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  assign valid = !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_sequencer.sv
// rtl/ps2_key_sequencer.sv - turns raw PS/2 scan bytes into make/break events with modifier snapshots
module ps2_key_sequencer
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              scan_strobe,
  input  logic [7:0]        scan_code,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_code,
  output logic              evt_ext,
  output logic              evt_release,
  output logic [MODS_W-1:0] evt_mods,
  output logic              overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);

  logic          strobe_meta;
  logic          strobe_sync;
  logic          strobe_prev;
  logic [1:0]    init_cnt;
  logic          byte_pulse;
  logic          byte_valid;
  logic [7:0]    byte_reg;
  ps2_state_t    state;
  logic [TW-1:0] tmo_cnt;
  ps2_keys_t     keys;
  logic          push_valid;
  ps2_evt_t      push_evt;
  logic [EVT_W-1:0] head_bits;
  ps2_evt_t      head_evt;

  // Edge detection stays blind until the synchroniser and prev flop hold real samples,
  // so a strobe already high at reset release never counts as a new byte.
  assign byte_pulse = strobe_sync && !strobe_prev && (init_cnt == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      strobe_meta <= 1'b0;
      strobe_sync <= 1'b0;
      strobe_prev <= 1'b0;
      init_cnt    <= 2'd0;
      byte_valid  <= 1'b0;
      byte_reg    <= 8'h00;
    end else begin
      strobe_meta <= scan_strobe;
      strobe_sync <= strobe_meta;
      strobe_prev <= strobe_sync;
      if (init_cnt != 2'd3) init_cnt <= init_cnt + 2'd1;
      byte_valid <= byte_pulse;
      if (byte_pulse) byte_reg <= scan_code;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      keys       <= '0;
      push_valid <= 1'b0;
      push_evt   <= '0;
    end else begin
      push_valid <= 1'b0;
      if (byte_valid) begin
        tmo_cnt <= '0;
        case (state)
          ST_IDLE: begin
            if (byte_reg == SC_EXT) state <= ST_EXT;
            else if (byte_reg == SC_BRK) state <= ST_BRK;
            else if (!is_ignored(byte_reg)) begin
              keys       <= key_update(keys, byte_reg, 1'b0, 1'b0);
              push_evt   <= build_evt(keys, byte_reg, 1'b0, 1'b0);
              push_valid <= 1'b1;
            end
          end
          ST_EXT: begin
            if (byte_reg == SC_BRK) state <= ST_EXT_BRK;
            else if (byte_reg != SC_EXT) begin
              keys       <= key_update(keys, byte_reg, 1'b1, 1'b0);
              push_evt   <= build_evt(keys, byte_reg, 1'b1, 1'b0);
              push_valid <= 1'b1;
              state      <= ST_IDLE;
            end
          end
          ST_BRK: begin
            keys       <= key_update(keys, byte_reg, 1'b0, 1'b1);
            push_evt   <= build_evt(keys, byte_reg, 1'b0, 1'b1);
            push_valid <= 1'b1;
            state      <= ST_IDLE;
          end
          default: begin
            keys       <= key_update(keys, byte_reg, 1'b1, 1'b1);
            push_evt   <= build_evt(keys, byte_reg, 1'b1, 1'b1);
            push_valid <= 1'b1;
            state      <= ST_IDLE;
          end
        endcase
      end else if (state != ST_IDLE) begin
        // A prefix with no follow-up byte is abandoned silently.
        if (tmo_cnt == TMO_LAST) begin
          state   <= ST_IDLE;
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_ONE;
        end
      end
    end
  end

  ps2_event_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(EVT_W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_valid),
    .push_data(push_evt),
    .pop      (evt_valid && evt_ready),
    .valid    (evt_valid),
    .head     (head_bits),
    .overflow (overflow)
  );

  assign head_evt    = head_bits;
  assign evt_code    = head_evt.code;
  assign evt_ext     = head_evt.ext;
  assign evt_release = head_evt.rel;
  assign evt_mods    = head_evt.mods;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// tb/tb_ps2_key_sequencer.sv - directed and randomized bench for ps2_key_sequencer
module tb_ps2_key_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       scan_strobe;
  logic [7:0] scan_code;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_release;
  logic [3:0] evt_mods;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  logic [13:0] obs[$];
  logic [13:0] exp_q[$];
  logic [13:0] got[$];

  bit         pend_e0;
  bit         pend_f0;
  bit         held [512];
  bit         caps_m;
  bit         rand_ready = 1'b0;
  logic [7:0] pool [12];

  always #5 clk = ~clk;

  ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scan_strobe(scan_strobe),
    .scan_code  (scan_code),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_code   (evt_code),
    .evt_ext    (evt_ext),
    .evt_release(evt_release),
    .evt_mods   (evt_mods),
    .overflow   (overflow)
  );

  // Every accepted handshake, packed {mods, release, ext, code}.
  always @(negedge clk)
    if (reset_n === 1'b1 && evt_valid === 1'b1 && evt_ready === 1'b1)
      obs.push_back({evt_mods, evt_release, evt_ext, evt_code});

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic bit ign(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  // Reference: a key is identified by its code, except ctrl/alt whose E0 form is a distinct key.
  function automatic void model_emit(input logic [7:0] b, input bit ext, input bit rel);
    int id;
    logic [3:0] m;
    id = ((b == 8'h14 || b == 8'h11) && ext) ? 256 + int'(b) : int'(b);
    if (b == 8'h58 && !rel && !held[8'h58]) caps_m = !caps_m;
    held[id] = !rel;
    m = {caps_m, held[8'h11] | held[256 + 8'h11], held[8'h14] | held[256 + 8'h14],
         held[8'h12] | held[8'h59]};
    exp_q.push_back({m, rel, ext, b});
    pend_e0 = 1'b0;
    pend_f0 = 1'b0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (pend_f0) model_emit(b, pend_e0, 1'b1);
    else if (b == 8'hE0) pend_e0 = 1'b1;
    else if (b == 8'hF0) pend_f0 = 1'b1;
    else if (pend_e0 || !ign(b)) model_emit(b, pend_e0, 1'b0);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 512; i++) held[i] = 1'b0;
    caps_m  = 1'b0;
    pend_e0 = 1'b0;
    pend_f0 = 1'b0;
    exp_q.delete();
    obs.delete();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) evt_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    tick();
    scan_code   = b;
    scan_strobe = 1'b1;
    model_byte(b);
    repeat (5) tick();
    scan_strobe = 1'b0;
    repeat (6) tick();
  endtask

  task automatic drain(input string tag);
    int n;
    rand_ready = 1'b0;
    evt_ready  = 1'b1;
    repeat (24) tick();
    evt_ready = 1'b0;
    chk({tag, "_count"}, obs.size(), exp_q.size());
    n = (obs.size() < exp_q.size()) ? obs.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_evt%0d", tag, i), obs[i], exp_q[i]);
    got = obs;
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'h75, 8'hAA, 8'h00, 8'h2C};
    model_reset();
    reset_n     = 1'b0;
    scan_strobe = 1'b1;
    scan_code   = 8'h1C;
    evt_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", evt_valid, 0);
    chk("rst_code", evt_code, 0);
    chk("rst_ext", evt_ext, 0);
    chk("rst_rel", evt_release, 0);
    chk("rst_mods", evt_mods, 0);
    chk("rst_ovf", overflow, 0);

    // Strobe already high at release must not create a byte.
    reset_n = 1'b1;
    repeat (10) tick();
    chk("no_pulse_after_rst", evt_valid, 0);
    scan_strobe = 1'b0;
    repeat (4) tick();
    chk("no_pulse_after_rst_low", evt_valid, 0);

    // Latency: evt_valid rises after edge k+4.
    tick();
    scan_code   = 8'h1C;
    scan_strobe = 1'b1;
    model_byte(8'h1C);
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lat_k3_valid", evt_valid, 0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_k4_valid", evt_valid, 1);
    chk("lat_code", evt_code, 8'h1C);
    chk("lat_ext", evt_ext, 0);
    chk("lat_rel", evt_release, 0);
    chk("lat_mods", evt_mods, 0);
    scan_strobe = 1'b0;
    repeat (3) tick();
    chk("hold_valid", evt_valid, 1);
    chk("hold_code", evt_code, 8'h1C);
    drain("lat");

    // Extended make then extended break.
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    drain("ext");
    chk("ext_make", got[0], {4'h0, 1'b0, 1'b1, 8'h75});
    chk("ext_break", got[1], {4'h0, 1'b1, 1'b1, 8'h75});

    // Shift snapshots, then caps toggle with typematic repeat.
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12);
    drain("shift");
    chk("shift_m0", got[0][13:10], 4'b0001);
    chk("shift_m1", got[1][13:10], 4'b0001);
    chk("shift_m2", got[2][13:10], 4'b0000);
    send_byte(8'h58); send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h58);
    drain("caps");
    chk("caps0", got[0][13], 1);
    chk("caps1", got[1][13], 1);
    chk("caps2", got[2][13], 1);
    chk("caps3", got[3][13], 0);

    // Overflow: six makes into a four-entry FIFO with no consumer.
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24);
    send_byte(8'h2D); send_byte(8'h2C); send_byte(8'h35);
    chk("ovf_set", overflow, 1);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    // Pop exactly on the edge the next push lands while full.
    tick();
    scan_code   = 8'h36;
    scan_strobe = 1'b1;
    model_byte(8'h36);
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1 evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    scan_strobe = 1'b0;
    repeat (6) tick();
    drain("full");
    chk("full_first", got[0][7:0], 8'h15);
    chk("full_last", got[4][7:0], 8'h36);
    chk("ovf_sticky", overflow, 1);

    // Abandoned break prefix.
    send_byte(8'hF0);
    repeat (150) tick();
    pend_e0 = 1'b0;
    pend_f0 = 1'b0;
    send_byte(8'h1C);
    drain("tmo");
    chk("tmo_rel", got[0][9], 0);
    chk("tmo_code", got[0][7:0], 8'h1C);

    // Reset mid-prefix with events queued.
    send_byte(8'h1C); send_byte(8'h1D); send_byte(8'hE0);
    chk("pre_rst_valid", evt_valid, 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_ovf", overflow, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    model_reset();
    repeat (5) tick();
    send_byte(8'h1C);
    drain("post_rst");
    chk("post_rst_ext", got[0][8], 0);

    // Random byte stream against the reference model.
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) send_byte(pool[$urandom_range(0, 11)]);
    drain("rand");
    chk("rand_no_ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
